// File: rtl/card_match_fsm.sv
// card_match_fsm
// ------------------------------------------------------------------------
// Game-control stage of a memory/concentration card game.
// - Accepts card selections from the input/deck stage.
// - Tracks which cards are face-up and which are matched.
// - After each second flip, compares the two face values and drives the
//   reveal timer with start_timer/delay.
// - On timer_done, either retires the pair as matched or flips both cards
//   back face-down.
// - Counts moves and pairs, and flags game completion.
//
// Optional feature: define MOVE_LIMIT_EN to enable a move limit. This adds
// the game_lost output and the MAX_MOVES parameter.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   sel_valid    in   one-cycle selection strobe
//   sel_idx      in   selected card index (IDX_W)
//   sel_val      in   face value of the selected card (VAL_W)
//   sel_reject   out  one-cycle pulse when a selection is ignored
//   start_timer  out  held high for the whole reveal wait
//   delay        out  reveal duration in clocks, stable while start_timer=1
//   timer_done   in   completion pulse from the reveal timer
//   face_up      out  revealed, unmatched cards (NUM_CARDS)
//   matched      out  retired cards (NUM_CARDS)
//   moves        out  completed pair attempts, saturating at 255
//   pairs        out  matched pair count (IDX_W)
//   game_over    out  sticky, set when the game ends
//   game_lost    out  (MOVE_LIMIT_EN only) move limit exhausted
module card_match_fsm #(
  parameter int          NUM_CARDS      = 16,
  parameter int          IDX_W          = 4,
  parameter int          VAL_W          = 3,
  parameter logic [15:0] MATCH_DELAY    = 16'd10000,
  parameter logic [15:0] MISMATCH_DELAY = 16'd50000
`ifdef MOVE_LIMIT_EN
  , parameter logic [7:0] MAX_MOVES     = 8'd40
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic [VAL_W-1:0]     sel_val,
  output logic                 sel_reject,
  output logic                 start_timer,
  output logic [15:0]          delay,
  input  logic                 timer_done,
  output logic [NUM_CARDS-1:0] face_up,
  output logic [NUM_CARDS-1:0] matched,
  output logic [7:0]           moves,
  output logic [IDX_W-1:0]     pairs,
  output logic                 game_over
`ifdef MOVE_LIMIT_EN
  , output logic               game_lost
`endif
);

  typedef enum logic [1:0] {IDLE, ONE_UP, WAIT, DONE} state_t;

  // One bit wider than sel_idx, so that out-of-range indices can be detected
  // even when NUM_CARDS == 2**IDX_W.
  localparam logic [IDX_W:0]   NUM_CARDS_EXT = (IDX_W+1)'(NUM_CARDS);
  localparam logic [IDX_W-1:0] PAIRS_LAST    = IDX_W'(NUM_CARDS/2 - 1);

  state_t               state_q, state_d;
  logic [NUM_CARDS-1:0] face_up_q, face_up_d;
  logic [NUM_CARDS-1:0] matched_q, matched_d;
  logic [7:0]           moves_q, moves_d;
  logic [IDX_W-1:0]     pairs_q, pairs_d;
  logic                 start_timer_q, start_timer_d;
  logic [15:0]          delay_q, delay_d;
  logic                 sel_reject_q, sel_reject_d;
  logic                 game_over_q, game_over_d;
  logic [IDX_W-1:0]     first_idx_q, first_idx_d;
  logic [VAL_W-1:0]     first_val_q, first_val_d;
  logic [IDX_W-1:0]     second_idx_q, second_idx_d;
  logic                 pair_eq_q, pair_eq_d;
`ifdef MOVE_LIMIT_EN
  logic                 game_lost_q, game_lost_d;
`endif

  // One-hot decodes of the incoming and latched indices.
  // An out-of-range index decodes to all zeros.
  logic [NUM_CARDS-1:0] sel_oh, first_oh, second_oh;

  for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_dec
    assign sel_oh[gi]    = (sel_idx      == IDX_W'(gi));
    assign first_oh[gi]  = (first_idx_q  == IDX_W'(gi));
    assign second_oh[gi] = (second_idx_q == IDX_W'(gi));
  end

  logic idx_ok, card_free, can_sel, accept;

  always_comb begin
    idx_ok    = ({1'b0, sel_idx} < NUM_CARDS_EXT);
    card_free = idx_ok && ((sel_oh & (face_up_q | matched_q)) == '0);
    can_sel   = (state_q == IDLE) || (state_q == ONE_UP);
    accept    = sel_valid && can_sel && card_free;
  end

  always_comb begin
    state_d       = state_q;
    face_up_d     = face_up_q;
    matched_d     = matched_q;
    moves_d       = moves_q;
    pairs_d       = pairs_q;
    start_timer_d = start_timer_q;
    delay_d       = delay_q;
    game_over_d   = game_over_q;
    first_idx_d   = first_idx_q;
    first_val_d   = first_val_q;
    second_idx_d  = second_idx_q;
    pair_eq_d     = pair_eq_q;
    sel_reject_d  = sel_valid && !accept;
`ifdef MOVE_LIMIT_EN
    game_lost_d   = game_lost_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          face_up_d   = face_up_q | sel_oh;
          first_idx_d = sel_idx;
          first_val_d = sel_val;
          state_d     = ONE_UP;
        end
      end

      ONE_UP: begin
        if (accept) begin
          face_up_d     = face_up_q | sel_oh;
          second_idx_d  = sel_idx;
          moves_d       = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          // The comparison result is kept so that WAIT need not re-derive
          // it from delay.
          pair_eq_d     = (sel_val == first_val_q);
          delay_d       = (sel_val == first_val_q) ? MATCH_DELAY : MISMATCH_DELAY;
          start_timer_d = 1'b1;
          state_d       = WAIT;
        end
      end

      WAIT: begin
        if (timer_done) begin
          start_timer_d = 1'b0;
          face_up_d     = face_up_q & ~(first_oh | second_oh);
          if (pair_eq_q) begin
            matched_d = matched_q | first_oh | second_oh;
            pairs_d   = pairs_q + 1'b1;
            if (pairs_q == PAIRS_LAST) begin
              game_over_d = 1'b1;
              state_d     = DONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
`ifdef MOVE_LIMIT_EN
            // Only a mismatch can exhaust the limit, so a winning match
            // always takes priority.
            if (moves_q >= MAX_MOVES) begin
              game_lost_d = 1'b1;
              game_over_d = 1'b1;
              state_d     = DONE;
            end
`endif
          end
        end
      end

      DONE: begin
        game_over_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      face_up_q     <= '0;
      matched_q     <= '0;
      moves_q       <= '0;
      pairs_q       <= '0;
      start_timer_q <= 1'b0;
      delay_q       <= '0;
      sel_reject_q  <= 1'b0;
      game_over_q   <= 1'b0;
      first_idx_q   <= '0;
      first_val_q   <= '0;
      second_idx_q  <= '0;
      pair_eq_q     <= 1'b0;
`ifdef MOVE_LIMIT_EN
      game_lost_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      face_up_q     <= face_up_d;
      matched_q     <= matched_d;
      moves_q       <= moves_d;
      pairs_q       <= pairs_d;
      start_timer_q <= start_timer_d;
      delay_q       <= delay_d;
      sel_reject_q  <= sel_reject_d;
      game_over_q   <= game_over_d;
      first_idx_q   <= first_idx_d;
      first_val_q   <= first_val_d;
      second_idx_q  <= second_idx_d;
      pair_eq_q     <= pair_eq_d;
`ifdef MOVE_LIMIT_EN
      game_lost_q   <= game_lost_d;
`endif
    end
  end

  assign sel_reject  = sel_reject_q;
  assign start_timer = start_timer_q;
  assign delay       = delay_q;
  assign face_up     = face_up_q;
  assign matched     = matched_q;
  assign moves       = moves_q;
  assign pairs       = pairs_q;
  assign game_over   = game_over_q;
`ifdef MOVE_LIMIT_EN
  assign game_lost   = game_lost_q;
`endif

endmodule

// File: tb/tb_card_match_fsm.sv
// Testbench for card_match_fsm.
// - A behavioural reference model predicts the registered outputs for each
//   cycle of stimulus.
// - Each prediction is pushed onto a scoreboard queue when the inputs are
//   driven.
// - The prediction is popped and compared one edge later.
// - IDX_W is widened to 5 so that an out-of-range index (16) can be driven.
module tb_card_match_fsm;

  localparam int N = 16;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          sel_valid;
  logic [IW-1:0] sel_idx;
  logic [2:0]    sel_val;
  logic          sel_reject;
  logic          start_timer;
  logic [15:0]   delay;
  logic          timer_done;
  logic [N-1:0]  face_up;
  logic [N-1:0]  matched;
  logic [7:0]    moves;
  logic [IW-1:0] pairs;
  logic          game_over;
`ifdef MOVE_LIMIT_EN
  logic          game_lost;
  localparam int LIMIT = 3;
`endif

  always #5 clk = ~clk;

  card_match_fsm #(
    .NUM_CARDS(N), .IDX_W(IW), .VAL_W(3),
    .MATCH_DELAY(16'd10000), .MISMATCH_DELAY(16'd50000)
`ifdef MOVE_LIMIT_EN
    , .MAX_MOVES(8'(LIMIT))
`endif
  ) dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .sel_val(sel_val), .sel_reject(sel_reject), .start_timer(start_timer),
    .delay(delay), .timer_done(timer_done), .face_up(face_up),
    .matched(matched), .moves(moves), .pairs(pairs), .game_over(game_over)
`ifdef MOVE_LIMIT_EN
    , .game_lost(game_lost)
`endif
  );

  typedef struct {
    logic [N-1:0] face, mat;
    logic [7:0]   mv;
    logic [IW-1:0] pr;
    logic         st, rej, over, lost;
    logic [15:0]  dly;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state.
  int           m_state;  // 0 idle, 1 one-up, 2 wait, 3 done
  logic [N-1:0] m_face, m_mat;
  int           m_moves, m_pairs, m_i1, m_i2, m_v1;
  bit           m_st, m_rej, m_over, m_lost, m_eq;
  logic [15:0]  m_dly;

  task automatic model(input bit rst, input bit sv, input int idx, input int val, input bit td);
    bit acc;
    if (rst) begin
      m_state = 0; m_face = '0; m_mat = '0; m_moves = 0; m_pairs = 0;
      m_st = 0; m_rej = 0; m_over = 0; m_lost = 0; m_dly = '0;
      return;
    end
    acc = 0;
    if (sv && m_state < 2 && idx < N)
      acc = !m_face[idx] && !m_mat[idx];
    m_rej = sv && !acc;
    if (acc && m_state == 0) begin
      m_face[idx] = 1'b1; m_i1 = idx; m_v1 = val; m_state = 1;
    end else if (acc && m_state == 1) begin
      m_face[idx] = 1'b1; m_i2 = idx;
      if (m_moves < 255) m_moves++;
      m_eq = (val == m_v1);
      m_dly = m_eq ? 16'd10000 : 16'd50000;
      m_st = 1; m_state = 2;
    end else if (m_state == 2 && td) begin
      m_st = 0; m_face[m_i1] = 1'b0; m_face[m_i2] = 1'b0;
      if (m_eq) begin
        m_mat[m_i1] = 1'b1; m_mat[m_i2] = 1'b1; m_pairs++;
        if (m_pairs == N/2) begin m_over = 1; m_state = 3; end
        else m_state = 0;
      end else begin
        m_state = 0;
`ifdef MOVE_LIMIT_EN
        if (m_moves >= LIMIT) begin m_lost = 1; m_over = 1; m_state = 3; end
`endif
      end
    end
  endtask

  // One clock of stimulus: predict, push, clock, pop and compare.
  task automatic step(input string tag, input bit rst, input bit sv, input int idx, input int val, input bit td);
    exp_t e, p;
    reset = rst; sel_valid = sv; sel_idx = IW'(idx); sel_val = 3'(val); timer_done = td;
    model(rst, sv, idx, val, td);
    e.face = m_face; e.mat = m_mat; e.mv = 8'(m_moves); e.pr = IW'(m_pairs);
    e.st = m_st; e.rej = m_rej; e.over = m_over; e.lost = m_lost; e.dly = m_dly;
    exp_q.push_back(e);
    @(posedge clk); #1;
    p = exp_q.pop_front();
    check_eq({tag, ".face_up"}, 32'(face_up), 32'(p.face));
    check_eq({tag, ".matched"}, 32'(matched), 32'(p.mat));
    check_eq({tag, ".moves"}, 32'(moves), 32'(p.mv));
    check_eq({tag, ".pairs"}, 32'(pairs), 32'(p.pr));
    check_eq({tag, ".start_timer"}, 32'(start_timer), 32'(p.st));
    check_eq({tag, ".delay"}, 32'(delay), 32'(p.dly));
    check_eq({tag, ".sel_reject"}, 32'(sel_reject), 32'(p.rej));
    check_eq({tag, ".game_over"}, 32'(game_over), 32'(p.over));
`ifdef MOVE_LIMIT_EN
    check_eq({tag, ".game_lost"}, 32'(game_lost), 32'(p.lost));
`endif
    n_txn++;
    $display("txn %0d %-12s rst=%0b sv=%0b idx=%0d val=%0d td=%0b -> face=%04h mat=%04h mv=%0d pr=%0d st=%0b dly=%0d rej=%0b over=%0b",
             n_txn, tag, rst, sv, idx, val, td, face_up, matched, moves, pairs,
             start_timer, delay, sel_reject, game_over);
    @(negedge clk);
  endtask

  task automatic sel(input string tag, input int idx, input int val);
    step(tag, 0, 1, idx, val, 0);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic done(input string tag);
    step(tag, 0, 0, 0, 0, 1);
  endtask

  task automatic play_pair(input int a, input int va, input int b, input int vb);
    sel("first", a, va);
    sel("second", b, vb);
    idle("reveal");
    done("timer_done");
  endtask

  initial begin
    int idxs[$];

    // Reset, then idle.
    step("reset", 1, 0, 0, 0, 0);
    step("reset2", 1, 0, 0, 0, 0);
    idle("idle");

    // Reset while waiting on the timer.
    sel("sel3", 3, 1);
    sel("sel7", 7, 2);
    idle("wait");
    step("rst_in_wait", 1, 0, 0, 0, 0);
    idle("post_rst");

    // Matching pair: 2 and 9, both value 5.
    sel("sel2", 2, 5);
    sel("sel9", 9, 5);
    idle("wait");
    idle("wait");
    done("match_done");

    // Mismatching pair: 0 (value 1) and 1 (value 3).
    play_pair(0, 1, 1, 3);

    // timer_done outside WAIT is ignored.
    done("td_idle");

    // Rejections.
    sel("sel4", 4, 2);
    sel("rej_faceup", 4, 2);
    sel("rej_matched", 2, 5);
    sel("rej_oor", 16, 0);
    sel("sel5", 5, 2);
    sel("rej_wait", 6, 0);
    step("rej_with_td", 0, 1, 6, 0, 1);
    idle("after");

    // Finish the board with the remaining unmatched cards.
    for (int i = 0; i < N; i++)
      if (!m_mat[i]) idxs.push_back(i);
    for (int k = 0; k + 1 < idxs.size(); k += 2)
      play_pair(idxs[k], 7, idxs[k+1], 7);
    sel("rej_done", 10, 0);
    idle("done_hold");

    // Fresh game with three mismatches (the move limit applies when enabled).
    step("reset3", 1, 0, 0, 0, 0);
    play_pair(0, 0, 1, 1);
    play_pair(2, 2, 3, 3);
    play_pair(4, 4, 5, 5);
    sel("after_3mm", 6, 0);
    idle("final");

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/card_match_fsm.md
# card_match_fsm

Game-control stage that feeds the reveal delay timer. It accepts card selections from the input/deck stage and tracks face-up and matched cards. After each second flip it compares the two card values, drives the timer's `start_timer`/`delay` handshake, and on `timer_done` either retires the pair as matched or flips both cards back. It counts moves and pairs and flags game completion.

## Interface
- `NUM_CARDS`, 16: cards on the board. Even, ≤ 2^IDX_W.
- `IDX_W`, 4: card index width.
- `VAL_W`, 3: card face-value width.
- `MATCH_DELAY`, 16'd10000: reveal time after a match, in clocks.
- `MISMATCH_DELAY`, 16'd50000: reveal time after a mismatch, in clocks.
- `MAX_MOVES`, 8'd40: move limit. Used only with `MOVE_LIMIT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `sel_valid`  in  1  one-cycle selection strobe.
- `sel_idx`  in  IDX_W  selected card index; qualified by `sel_valid`.
- `sel_val`  in  VAL_W  face value of `sel_idx`; qualified by `sel_valid`.
- `sel_reject`  out  1  registered one-cycle pulse when a selection is ignored.
- `start_timer`  out  1  held high for the whole reveal wait.
- `delay`  out  16  reveal duration; stable while `start_timer` is high.
- `timer_done`  in  1  completion pulse from the timer.
- `face_up`  out  NUM_CARDS  currently revealed, unmatched cards.
- `matched`  out  NUM_CARDS  retired cards.
- `moves`  out  8  completed pair attempts; saturates at 255.
- `pairs`  out  IDX_W  matched pairs.
- `game_over`  out  1  sticky; set when every pair is matched.
- `game_lost`  out  1  present only with `MOVE_LIMIT_EN`.

## Operation
- States: IDLE, ONE_UP, WAIT, DONE. Reset enters IDLE.
- A selection is accepted only if all of the following hold:
  - state is IDLE or ONE_UP;
  - `sel_idx` < NUM_CARDS;
  - `face_up[sel_idx]` = 0 and `matched[sel_idx]` = 0.
- Any other `sel_valid` causes `sel_reject` = 1 on the next cycle and no other change.
- IDLE, accept: set `face_up[idx]`; latch first index and value; go to ONE_UP.
- ONE_UP, accept:
  - set `face_up[idx]`; latch second index;
  - `moves` +1 (saturating);
  - `delay` ← MATCH_DELAY if the values are equal, else MISMATCH_DELAY;
  - `start_timer` ← 1; go to WAIT.
- WAIT: hold `start_timer` and `delay`. On `timer_done`:
  - `start_timer` ← 0; clear `face_up` for both indices.
  - Match: set `matched` for both; `pairs` +1. If `pairs` reaches NUM_CARDS/2, go to DONE; otherwise go to IDLE.
  - Mismatch: go to IDLE.
- DONE: `game_over` = 1. All selections are rejected. Stays in DONE until `reset`.
- `timer_done` outside WAIT is ignored.

## Timing
- Reset values: `face_up` = 0, `matched` = 0, `moves` = 0, `pairs` = 0, `start_timer` = 0, `delay` = 0, `sel_reject` = 0, `game_over` = 0, `game_lost` = 0.
- All outputs are registered. A selection at edge N is visible (`face_up`, `start_timer`, `delay`, `sel_reject`) after edge N.
- `delay` is written on the same edge that raises `start_timer` and never changes while `start_timer` is high.
- `timer_done` sampled at edge T: `start_timer` is low, and `face_up`/`matched`/`pairs`/state are updated, after edge T. The first new selection can be accepted at edge T+1.
- `sel_valid` coincident with `timer_done` is rejected.
- `reset` in any state, including WAIT, returns everything to reset values at that edge. `start_timer` dropping is the only abort signal to the timer.

## Configuration
- `MOVE_LIMIT_EN` defined:
  - adds output `game_lost`;
  - when a mismatch resolves in WAIT with `moves` ≥ MAX_MOVES and the game is not won, go to DONE with `game_lost` = 1 and `game_over` = 1;
  - a winning match takes priority over the limit.
- `MOVE_LIMIT_EN` undefined: no `game_lost` port, no move limit, and `MAX_MOVES` is unused.

## Test plan
- Reset then idle: all outputs 0, state IDLE. Assert `reset` during WAIT with `start_timer` = 1: next cycle `start_timer` = 0 and `face_up` = 0.
- Select idx 2 (val 5) then idx 9 (val 5): `start_timer` = 1, `delay` = 10000, `moves` = 1. Pulse `timer_done`: `matched` = 0x0204, `face_up` = 0, `pairs` = 1.
- Select idx 0 (val 1) then idx 1 (val 3): `delay` = 50000. `timer_done`: `face_up` = 0, `matched` unchanged, state IDLE.
- Re-select a face-up card, select a matched card, select idx 16, and select during WAIT: each gives `sel_reject` = 1 for one cycle with no state change.
- Match all 8 pairs: `pairs` = 8, `game_over` = 1. A further `sel_valid` gives `sel_reject` = 1.
- With `MOVE_LIMIT_EN` and MAX_MOVES = 3: three mismatches give `game_lost` = 1 and `game_over` = 1 after the third `timer_done`.
